// File: rtl/lookahead_sample_buffer_pkg.sv
// lookahead_buf_p: shared constants and bank/width helpers for the lookahead sample buffer
package lookahead_buf_p;
  localparam int M_DEF = 4;
  localparam int DSR_DEF = 12;
  localparam int LA_WORDS_DEF = 16;
  localparam int SampleWidth = M_DEF * DSR_DEF;
  localparam int BANK_CNT = 3;
  typedef logic [1:0] bank_t;
  function automatic bank_t bank_dec(bank_t b);
    return b == 2'd0 ? bank_t'(BANK_CNT - 1) : b - 2'd1;
  endfunction
  function automatic bank_t bank_inc(bank_t b);
    return b == bank_t'(BANK_CNT - 1) ? 2'd0 : b + 2'd1;
  endfunction
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lookahead_sample_buffer_if.sv
// lookahead_sample_buffer_if: sample input and recursion-stage output bundle
interface lookahead_sample_buffer_if import lookahead_buf_p::*; #(
  parameter int M = M_DEF,
  parameter int DSR = DSR_DEF
);
  logic in_valid;
  logic [M-1:0] in_sample;
  logic out_strobe;
  logic [M*DSR-1:0] sample_out;
  logic [M*DSR-1:0] lookahead_out;
  logic valid_out;
  logic propagate;
  modport master (output in_valid, in_sample, input out_strobe, sample_out, lookahead_out, valid_out, propagate);
  modport slave (input in_valid, in_sample, output out_strobe, sample_out, lookahead_out, valid_out, propagate);
endinterface

// File: rtl/lookahead_sample_buffer_sample_bank_ram.sv
// sample_bank_ram: 3-bank word store, one write port and two registered read ports
module sample_bank_ram import lookahead_buf_p::*; #(
  parameter int W = SampleWidth,
  parameter int WORDS = LA_WORDS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  bank_t wbank,
  input  logic [cnt_w(WORDS)-1:0] widx,
  input  logic [W-1:0] wdata,
  input  logic re,
  input  bank_t rbank_a,
  input  bank_t rbank_b,
  input  logic [cnt_w(WORDS)-1:0] ridx,
  output logic [W-1:0] rdata_a,
  output logic [W-1:0] rdata_b
);
  localparam int IW = cnt_w(WORDS);
  localparam int AW = cnt_w(BANK_CNT * WORDS);
  logic [W-1:0] mem [BANK_CNT*WORDS];
  function automatic logic [AW-1:0] addr(bank_t b, logic [IW-1:0] i);
    return AW'(int'(b) * WORDS + int'(i));
  endfunction
  // read registers double as the top-level outputs, so they reset and hold between reads
  always_ff @(posedge clk) begin
    if (we) mem[addr(wbank, widx)] <= wdata;
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= mem[addr(rbank_a, ridx)];
      rdata_b <= mem[addr(rbank_b, ridx)];
    end
  end
endmodule

// File: rtl/lookahead_sample_buffer.sv
// lookahead_sample_buffer: packs control samples into words and replays bank pairs in reverse order
module lookahead_sample_buffer import lookahead_buf_p::*; #(
  parameter int M = M_DEF,
  parameter int DSR = DSR_DEF,
  parameter int LA_WORDS = LA_WORDS_DEF
) (
  input logic clk,
  input logic rst,
  lookahead_sample_buffer_if.slave bus
);
  localparam int SW = M * DSR;
  localparam int CW = cnt_w(DSR);
  localparam int IW = cnt_w(LA_WORDS);
  logic [CW-1:0] samp_cnt;
  logic [IW-1:0] word_idx, rd_idx;
  bank_t wr_bank;
  logic [1:0] fill;
  logic [SW-1:0] pack, word;
  logic word_done, bank_done, strobe_q, prop_q, valid_q;
  always_comb begin
    word = pack;
    word[M*int'(samp_cnt) +: M] = bus.in_sample;
  end
  assign word_done = bus.in_valid && samp_cnt == CW'(DSR - 1);
  assign bank_done = word_done && word_idx == IW'(LA_WORDS - 1);
  assign rd_idx = IW'(LA_WORDS - 1) - word_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt <= '0;
      word_idx <= '0;
      wr_bank <= '0;
      fill <= '0;
      pack <= '0;
      strobe_q <= 1'b0;
      prop_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      strobe_q <= word_done;
      prop_q <= word_done && word_idx == '0;
      valid_q <= valid_q || (word_done && fill == 2'd2);
      if (bus.in_valid) begin
        pack <= word;
        samp_cnt <= word_done ? '0 : samp_cnt + 1'b1;
      end
      if (word_done) word_idx <= bank_done ? '0 : word_idx + 1'b1;
      if (bank_done) begin
        wr_bank <= bank_inc(wr_bank);
        fill <= fill == 2'd2 ? 2'd2 : fill + 2'd1;
      end
    end
  end
  sample_bank_ram #(.W(SW), .WORDS(LA_WORDS)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(word_done && !rst),
    .wbank(wr_bank),
    .widx(word_idx),
    .wdata(word),
    .re(word_done),
    .rbank_a(bank_dec(wr_bank)),
    .rbank_b(bank_dec(bank_dec(wr_bank))),
    .ridx(rd_idx),
    .rdata_a(bus.lookahead_out),
    .rdata_b(bus.sample_out)
  );
  assign bus.out_strobe = strobe_q;
  assign bus.propagate = prop_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_lookahead_sample_buffer.sv
// tb_lookahead_sample_buffer: directed checks on a small (2,2,4) and a full-size (4,12,16) buffer
module tb_lookahead_sample_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  lookahead_sample_buffer_if #(.M(2), .DSR(2)) a();
  lookahead_sample_buffer_if #(.M(4), .DSR(12)) b();
  lookahead_sample_buffer #(.M(2), .DSR(2), .LA_WORDS(4)) u_small (.clk(clk), .rst(rst), .bus(a.slave));
  lookahead_sample_buffer #(.M(4), .DSR(12), .LA_WORDS(16)) u_big (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (a.out_strobe !== 1'b0) begin errors++; $display("FAIL reset strobe got=%b exp=0", a.out_strobe); end
    checks++;
    if (a.propagate !== 1'b0) begin errors++; $display("FAIL reset propagate got=%b exp=0", a.propagate); end
    checks++;
    if (a.valid_out !== 1'b0) begin errors++; $display("FAIL reset valid got=%b exp=0", a.valid_out); end
    checks++;
    if (a.sample_out !== 4'h0) begin errors++; $display("FAIL reset sample_out got=%h exp=0", a.sample_out); end
    checks++;
    if (a.lookahead_out !== 4'h0) begin errors++; $display("FAIL reset lookahead_out got=%h exp=0", a.lookahead_out); end
    checks++;
    if ({b.out_strobe, b.propagate, b.valid_out} !== 3'b000) begin errors++; $display("FAIL reset big ctrl got=%b exp=000", {b.out_strobe, b.propagate, b.valid_out}); end
    checks++;
    if (b.sample_out !== 48'h0 || b.lookahead_out !== 48'h0) begin errors++; $display("FAIL reset big data got=%h/%h exp=0", b.sample_out, b.lookahead_out); end
    checks++;
  endtask

  // words n=0..11 hold value n; gap idle cycles follow every accepted sample
  task automatic test_replay(input int gap);
    int k, wi, n;
    logic [3:0] w, exp_la, exp_cmp;
    logic v, st, exp_prop, exp_valid;
    do_reset();
    k = 0; wi = 0; exp_la = '0; exp_cmp = '0;
    for (int c = 0; c < 24 * (gap + 1); c++) begin
      v = (c % (gap + 1)) == 0;
      n = c / (gap + 1);
      w = 4'(n / 2);
      a.in_valid = v;
      a.in_sample = v ? ((n % 2) == 1 ? w[3:2] : w[1:0]) : 2'b11;
      cycle();
      st = v && (n % 2) == 1;
      if (st) begin
        k++;
        wi = k - 1;
        if (k >= 9) begin
          exp_la = 4'((wi / 4 - 1) * 4 + 3 - wi % 4);
          exp_cmp = 4'((wi / 4 - 2) * 4 + 3 - wi % 4);
        end
      end
      exp_prop = st && (wi % 4) == 0;
      exp_valid = k >= 9;
      if (a.out_strobe !== st) begin errors++; $display("FAIL replay strobe gap=%0d cyc=%0d got=%b exp=%b", gap, c, a.out_strobe, st); end
      checks++;
      if (a.propagate !== exp_prop) begin errors++; $display("FAIL replay propagate gap=%0d cyc=%0d got=%b exp=%b", gap, c, a.propagate, exp_prop); end
      checks++;
      if (a.valid_out !== exp_valid) begin errors++; $display("FAIL replay valid gap=%0d cyc=%0d got=%b exp=%b", gap, c, a.valid_out, exp_valid); end
      checks++;
      if (k >= 9) begin
        if (a.lookahead_out !== exp_la) begin errors++; $display("FAIL replay lookahead gap=%0d cyc=%0d got=%0d exp=%0d", gap, c, a.lookahead_out, exp_la); end
        checks++;
        if (a.sample_out !== exp_cmp) begin errors++; $display("FAIL replay sample gap=%0d cyc=%0d got=%0d exp=%0d", gap, c, a.sample_out, exp_cmp); end
        checks++;
      end
    end
    a.in_valid = 1'b0;
  endtask

  // samples 1,2 form word 0 = 4'b1001, read back as compute word on strobe 12
  task automatic test_packing();
    do_reset();
    for (int n = 0; n < 24; n++) begin
      a.in_valid = 1'b1;
      a.in_sample = n == 0 ? 2'd1 : n == 1 ? 2'd2 : 2'd0;
      cycle();
    end
    a.in_valid = 1'b0;
    if (a.out_strobe !== 1'b1) begin errors++; $display("FAIL pack strobe got=%b exp=1", a.out_strobe); end
    checks++;
    if (a.sample_out !== 4'b1001) begin errors++; $display("FAIL pack sample_out got=%b exp=1001", a.sample_out); end
    checks++;
    if (a.lookahead_out !== 4'b0000) begin errors++; $display("FAIL pack lookahead_out got=%b exp=0000", a.lookahead_out); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic exp_st, exp_valid;
    do_reset();
    for (int n = 0; n < 35; n++) begin
      a.in_valid = 1'b1;
      a.in_sample = 2'(n);
      cycle();
    end
    if (a.valid_out !== 1'b1) begin errors++; $display("FAIL mid pre-reset valid got=%b exp=1", a.valid_out); end
    checks++;
    a.in_sample = 2'd3;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    if ({a.out_strobe, a.propagate, a.valid_out} !== 3'b000) begin errors++; $display("FAIL mid reset ctrl got=%b exp=000", {a.out_strobe, a.propagate, a.valid_out}); end
    checks++;
    if (a.sample_out !== 4'h0 || a.lookahead_out !== 4'h0) begin errors++; $display("FAIL mid reset data got=%h/%h exp=0/0", a.sample_out, a.lookahead_out); end
    checks++;
    for (int n = 0; n < 18; n++) begin
      a.in_sample = 2'(n + 1);
      cycle();
      exp_st = (n % 2) == 1;
      exp_valid = n == 17;
      if (a.out_strobe !== exp_st) begin errors++; $display("FAIL mid strobe n=%0d got=%b exp=%b", n, a.out_strobe, exp_st); end
      checks++;
      if (a.valid_out !== exp_valid) begin errors++; $display("FAIL mid valid n=%0d got=%b exp=%b", n, a.valid_out, exp_valid); end
      checks++;
      if (n == 1 && a.propagate !== 1'b1) begin errors++; $display("FAIL mid first propagate got=%b exp=1", a.propagate); end
      if (n == 1) checks++;
    end
    a.in_valid = 1'b0;
  endtask

  task automatic test_bank_wrap();
    logic [47:0] words [192];
    logic [47:0] exp_la, exp_cmp;
    logic exp_prop, exp_valid;
    int rd;
    for (int i = 0; i < 192; i++) words[i] = {16'($urandom), $urandom};
    do_reset();
    for (int wi = 0; wi < 192; wi++) begin
      for (int j = 0; j < 12; j++) begin
        b.in_valid = 1'b1;
        b.in_sample = words[wi][4*j +: 4];
        cycle();
        if (j < 11) begin
          if (b.out_strobe !== 1'b0) begin errors++; $display("FAIL wrap idle strobe w=%0d j=%0d got=%b exp=0", wi, j, b.out_strobe); end
          checks++;
        end
      end
      exp_prop = (wi % 16) == 0;
      exp_valid = wi >= 32;
      if (b.out_strobe !== 1'b1) begin errors++; $display("FAIL wrap strobe w=%0d got=%b exp=1", wi, b.out_strobe); end
      checks++;
      if (b.propagate !== exp_prop) begin errors++; $display("FAIL wrap propagate w=%0d got=%b exp=%b", wi, b.propagate, exp_prop); end
      checks++;
      if (b.valid_out !== exp_valid) begin errors++; $display("FAIL wrap valid w=%0d got=%b exp=%b", wi, b.valid_out, exp_valid); end
      checks++;
      if (wi >= 32) begin
        rd = 15 - wi % 16;
        exp_la = words[(wi / 16 - 1) * 16 + rd];
        exp_cmp = words[(wi / 16 - 2) * 16 + rd];
        if (b.lookahead_out !== exp_la) begin errors++; $display("FAIL wrap lookahead w=%0d got=%h exp=%h", wi, b.lookahead_out, exp_la); end
        checks++;
        if (b.sample_out !== exp_cmp) begin errors++; $display("FAIL wrap sample w=%0d got=%h exp=%h", wi, b.sample_out, exp_cmp); end
        checks++;
      end
    end
    b.in_valid = 1'b0;
  endtask

  initial begin
    a.in_valid = 1'b0;
    a.in_sample = '0;
    b.in_valid = 1'b0;
    b.in_sample = '0;
    test_reset();
    test_replay(0);
    test_replay(1);
    test_packing();
    test_reset_mid();
    test_bank_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
